sram_like_arbiter: RTL
======================

// Module: sram_like_arbiter
// PURPOSE
//  Two-to-one arbiter that shares a single SRAM-like master port between the instruction-fetch
//  requester (inst_*) and the MEM-stage data requester (data_*, the m_data_* outputs of the
//  memory stage). Allows one transaction in flight at a time. Locks the grant from request to
//  response. Routes addr_ok/data_ok/rdata back only to the owning requester. Sits between the
//  core and the bus bridge (cache or AXI converter).
// PARAMETERS
//  ADDR_W   32  address width of all ports
//  DATA_W   32  data width of all ports
//  RR_ARB   0   0: data side has fixed priority; 1: round-robin on simultaneous requests
// PORTS
//  clk             in   1       core clock, rising edge
//  rst             in   1       asynchronous reset, active high
//  inst_req        in   1       instruction request, held until inst_addr_ok
//  inst_wr         in   1       instruction write flag (normally 0)
//  inst_size       in   2       0=byte 1=half 2=word
//  inst_addr       in   ADDR_W  instruction address
//  inst_wdata      in   DATA_W  instruction write data
//  inst_addr_ok    out  1       instruction address accepted
//  inst_data_ok    out  1       instruction response valid
//  inst_rdata      out  DATA_W  instruction read data
//  data_req        in   1       data request, held until data_addr_ok
//  data_wr         in   1       data write flag
//  data_size       in   2       data size
//  data_addr       in   ADDR_W  data address
//  data_wdata      in   DATA_W  data write data
//  data_addr_ok    out  1       data address accepted
//  data_data_ok    out  1       data response valid
//  data_rdata      out  DATA_W  data read data
//  bus_req         out  1       master request
//  bus_wr          out  1       master write flag
//  bus_size        out  2       master size
//  bus_addr        out  ADDR_W  master address
//  bus_wdata       out  DATA_W  master write data
//  bus_addr_ok     in   1       slave accepted address
//  bus_data_ok     in   1       slave response valid
//  bus_rdata       in   DATA_W  slave read data
//  busy            out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - States: IDLE, REQ (grant locked, waiting bus_addr_ok), WAIT (waiting bus_data_ok).
//    Owner register own: 0=inst, 1=data. last_grant register is used when RR_ARB=1.
//  - In IDLE, arbitration is combinational:
//    - If only one side requests, that side is selected.
//    - If both request, data wins when RR_ARB=0. When RR_ARB=1, the side opposite to
//      last_grant wins.
//  - In IDLE with a selected side:
//    - bus_* are driven from that side in the same cycle (0-cycle latency).
//    - own and last_grant are loaded with the selected side.
//    - If bus_addr_ok is 1 in that cycle, go to WAIT; otherwise go to REQ.
//  - In REQ:
//    - bus_* are driven from the owner side only. The other side's req is ignored.
//    - On bus_addr_ok, go to WAIT.
//    - If the owner drops req before addr_ok (protocol violation), go to IDLE and drop the
//      request.
//  - In WAIT:
//    - bus_req is 0.
//    - On bus_data_ok, pulse <own>_data_ok for exactly that cycle and go to IDLE.
//    - No new request is forwarded in the data_ok cycle. A new request issues no earlier than
//      the next cycle.
//  - <side>_addr_ok = bus_addr_ok & bus_req & (side is selected/owner), combinational.
//  - inst_rdata and data_rdata both mirror bus_rdata; only the owner's data_ok qualifies it.
//  - bus_data_ok in IDLE or REQ (stale response) is ignored. No requester data_ok is raised.
//  - When bus_req=0, bus_wr, bus_size, bus_addr and bus_wdata are driven to 0.
//  - Reset (asynchronous, any state): state=IDLE, own=0, last_grant=0 (next tie goes to data).
//    - All outputs are 0 while rst is 1.
//    - An in-flight transaction is abandoned. Its late data_ok is dropped per the rule above.
//  - Throughput: a transaction takes at least 2 cycles (addr_ok, then data_ok); back-to-back
//    IDLE->WAIT->IDLE.
// TESTING
//  1. Single inst read at 0xBFC00000, bus_addr_ok same cycle, data_ok 2 cycles later with
//     rdata=0x3C1D0000 -> inst_data_ok pulses once with rdata=0x3C1D0000; data_data_ok stays 0.
//  2. RR_ARB=0, inst_req and data_req both high in IDLE -> data granted; inst granted next
//     after data's data_ok; data_data_ok precedes inst_data_ok.
//  3. RR_ARB=1, both sides request continuously for 4 transactions -> grants alternate
//     D,I,D,I.
//  4. Inst wins IDLE with bus_addr_ok=0 for 3 cycles while data_req rises -> bus_addr stays
//     inst_addr, state REQ, data_addr_ok=0; data is served after inst completes.
//  5. Data write, addr 0x80001004, size=2, wdata=0xDEADBEEF -> bus_wr=1 with matching
//     size/addr/wdata; data_data_ok on write ack.
//  6. Assert rst during WAIT, then bus_data_ok arrives after rst release -> no *_data_ok
//     pulse; busy=0; next request is arbitrated normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like master port between instruction fetch and data access.
// One transaction in flight; grant is locked from request to response.
module sram_like_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RR_ARB = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic SIDE_INST = 1'b0;
    localparam logic SIDE_DATA = 1'b1;

    state_e state_q, state_d;
    logic   own_q, own_d;
    logic   last_q, last_d;
    logic   sel_side;
    logic   owner_req;
    logic   cur_side;
    logic   cur_valid;

    // Arbitration among requesters seen in IDLE; a tie goes opposite to last_q in round-robin mode
    always_comb begin
        sel_side = SIDE_INST;
        if (data_req && !inst_req) begin
            sel_side = SIDE_DATA;
        end else if (data_req && inst_req) begin
            sel_side = (RR_ARB != 0) ? ~last_q : SIDE_DATA;
        end
    end

    assign owner_req = (own_q == SIDE_DATA) ? data_req : inst_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= SIDE_INST;
            last_q  <= SIDE_INST;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    own_d   = sel_side;
                    last_d  = sel_side;
                    state_d = bus_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                // Owner withdrawing before acceptance abandons the request
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (bus_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_side  = own_q;
        case (state_q)
            IDLE: begin
                cur_valid = inst_req || data_req;
                cur_side  = sel_side;
            end
            REQ:     cur_valid = owner_req;
            default: cur_valid = 1'b0;
        endcase

        bus_req   = cur_valid && !rst;
        bus_wr    = 1'b0;
        bus_size  = 2'b00;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_req) begin
            if (cur_side == SIDE_DATA) begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end else begin
                bus_wr    = inst_wr;
                bus_size  = inst_size;
                bus_addr  = inst_addr;
                bus_wdata = inst_wdata;
            end
        end

        inst_addr_ok = bus_addr_ok && bus_req && (cur_side == SIDE_INST);
        data_addr_ok = bus_addr_ok && bus_req && (cur_side == SIDE_DATA);
        // Responses outside WAIT are stale and never reach a requester
        inst_data_ok = !rst && (state_q == WAIT) && bus_data_ok && (own_q == SIDE_INST);
        data_data_ok = !rst && (state_q == WAIT) && bus_data_ok && (own_q == SIDE_DATA);
        inst_rdata   = rst ? '0 : bus_rdata;
        data_rdata   = rst ? '0 : bus_rdata;
        busy         = !rst && (state_q != IDLE);
    end

endmodule
